mips_multicycle_ctrl: RTL and testbench

Moore-style control unit that sequences the MIPS datapath as a multi-cycle machine. It replaces the externally driven control inputs (ALU operation, register/memory write enables, mux selects) with a state machine. The state machine decodes the latched instruction's opcode/funct and steps through fetch, decode, execute, memory and writeback. It sits beside the datapath at top level, sharing its clock, and also owns PC-enable generation for branches.

---
 rtl/mips_multicycle_ctrl_if.sv | 54 +++++
 rtl/mips_multicycle_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if
//   Bundles the signals between the multi-cycle control unit and the MIPS
//   datapath.
//
//   Datapath -> control (status):
//     opcode[5:0]      Instruction[31:26] from the instruction register
//     funct[5:0]       Instruction[5:0]
//     zero             ALU zero flag
//     mem_ready        memory access completes this cycle
//   Control -> datapath (control):
//     pc_en, ir_write, i_or_d, mem_write, reg_write, reg_dst, mem_to_reg,
//     alu_src_a, alu_src_b[1:0], alu_control[2:0], pc_src[1:0]
//   Control -> observers:
//     instr_done       one-cycle pulse on the last cycle of each instruction
//     illegal_op       one-cycle pulse in DECODE for an unsupported encoding
//
//   Modports: master = control unit, slave = datapath.
//   Handshake: mem_ready is a plain "access complete this cycle" strobe. The
//   control unit holds its memory-side outputs stable in a wait state and
//   advances on the rising edge at which mem_ready is sampled high.
interface mips_multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       pc_en;
  logic       ir_write;
  logic       i_or_d;
  logic       mem_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic [1:0] pc_src;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_en, ir_write, i_or_d, mem_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_control, pc_src,
           instr_done, illegal_op
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_en, ir_write, i_or_d, mem_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_control, pc_src,
           instr_done, illegal_op
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
//   Moore-style multi-cycle control unit for the MIPS datapath. Sequences
//   FETCH -> DECODE -> (MEMADR/EXECUTE/BRANCH/ADDIEX/JUMP) -> ... -> FETCH,
//   driving ALU operation, enables and mux selects from the state register
//   plus opcode/funct/zero/mem_ready. Nothing but the state is registered.
//
//   Ports:
//     clk        clock, rising edge
//     reset      asynchronous, active-high; forces FETCH and masks all enables
//     bus        mips_multicycle_ctrl_if.master (status in, control out)
//     dbgState   current state encoding, for observation only
//
//   Parameters:
//     WAIT_EN_DEFAULT  1: honour mem_ready; 0: treat mem_ready as always 1
//
//   Build option:
//     MC_CTRL_JUMP_EN  when defined, opcode 000010 (j) executes via the JUMP
//                      state; otherwise it is decoded as illegal.
module mips_multicycle_ctrl #(
  parameter bit WAIT_EN_DEFAULT = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  mips_multicycle_ctrl_if.master       bus,
  output logic [3:0]                   dbgState
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10
`ifdef MC_CTRL_JUMP_EN
    ,
    S_JUMP     = 4'd11
`endif
  } ctrlState_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef MC_CTRL_JUMP_EN
  localparam logic [5:0] OP_J     = 6'b000010;
`endif

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  ctrlState_t state, nextState;

  logic       memReady;
  logic       functOk;
  logic [2:0] functAlu;

  // Raw (ungated) control values from the FSM decode.
  logic       pcEn, irWrite, iOrD, memWrite, regWrite, regDst, memToReg;
  logic       aluSrcA;
  logic [1:0] aluSrcB;
  logic [2:0] aluControl;
  logic [1:0] pcSrc;
  logic       instrDone, illegalOp;

  assign memReady = WAIT_EN_DEFAULT ? bus.mem_ready : 1'b1;

  // R-type funct decode, shared by DECODE (legality) and EXECUTE (ALU op).
  always_comb begin
    functOk  = 1'b1;
    functAlu = ALU_ADD;
    case (bus.funct)
      FN_ADD:  functAlu = ALU_ADD;
      FN_SUB:  functAlu = ALU_SUB;
      FN_AND:  functAlu = ALU_AND;
      FN_OR:   functAlu = ALU_OR;
      FN_SLT:  functAlu = ALU_SLT;
      default: functOk  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= nextState;
  end

  always_comb begin
    nextState  = state;
    pcEn       = 1'b0;
    irWrite    = 1'b0;
    iOrD       = 1'b0;
    memWrite   = 1'b0;
    regWrite   = 1'b0;
    regDst     = 1'b0;
    memToReg   = 1'b0;
    aluSrcA    = 1'b0;
    aluSrcB    = 2'b00;
    aluControl = ALU_ADD;
    pcSrc      = 2'b00;
    instrDone  = 1'b0;
    illegalOp  = 1'b0;

    case (state)
      S_FETCH: begin
        // PC+1 through the ALU; IR and PC load only when the fetch completes.
        aluSrcB = 2'b01;
        irWrite = memReady;
        pcEn    = memReady;
        if (memReady) nextState = S_DECODE;
      end

      S_DECODE: begin
        // Precompute the branch target PC+1+SignImm into ALUOut.
        aluSrcB = 2'b10;
        case (bus.opcode)
          OP_LW, OP_SW: nextState = S_MEMADR;
          OP_BEQ:       nextState = S_BRANCH;
          OP_ADDI:      nextState = S_ADDIEX;
`ifdef MC_CTRL_JUMP_EN
          OP_J:         nextState = S_JUMP;
`endif
          OP_RTYPE: begin
            if (functOk) begin
              nextState = S_EXECUTE;
            end else begin
              illegalOp = 1'b1;
              instrDone = 1'b1;
              nextState = S_FETCH;
            end
          end
          default: begin
            // PC already advanced in FETCH, so the instruction is skipped.
            illegalOp = 1'b1;
            instrDone = 1'b1;
            nextState = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        aluSrcA   = 1'b1;
        aluSrcB   = 2'b10;
        nextState = (bus.opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end

      S_MEMREAD: begin
        iOrD = 1'b1;
        if (memReady) nextState = S_MEMWB;
      end

      S_MEMWB: begin
        regWrite  = 1'b1;
        memToReg  = 1'b1;
        instrDone = 1'b1;
        nextState = S_FETCH;
      end

      S_MEMWRITE: begin
        // mem_write is held across wait cycles; the store completes on ready.
        iOrD      = 1'b1;
        memWrite  = 1'b1;
        instrDone = memReady;
        if (memReady) nextState = S_FETCH;
      end

      S_EXECUTE: begin
        aluSrcA    = 1'b1;
        aluControl = functAlu;
        nextState  = S_ALUWB;
      end

      S_ALUWB: begin
        regWrite  = 1'b1;
        regDst    = 1'b1;
        instrDone = 1'b1;
        nextState = S_FETCH;
      end

      S_BRANCH: begin
        aluSrcA    = 1'b1;
        aluControl = ALU_SUB;
        pcSrc      = 2'b01;
        pcEn       = bus.zero;
        instrDone  = 1'b1;
        nextState  = S_FETCH;
      end

      S_ADDIEX: begin
        aluSrcA   = 1'b1;
        aluSrcB   = 2'b10;
        nextState = S_ADDIWB;
      end

      S_ADDIWB: begin
        regWrite  = 1'b1;
        instrDone = 1'b1;
        nextState = S_FETCH;
      end

`ifdef MC_CTRL_JUMP_EN
      S_JUMP: begin
        pcSrc     = 2'b10;
        pcEn      = 1'b1;
        instrDone = 1'b1;
        nextState = S_FETCH;
      end
`endif

      default: nextState = S_FETCH;
    endcase
  end

  // Enables and pulses are masked while reset is high so that an aborted
  // instruction cannot leave a partial write; selects need no masking since
  // reset already holds the state in FETCH.
  assign bus.pc_en       = pcEn      & ~reset;
  assign bus.ir_write    = irWrite   & ~reset;
  assign bus.mem_write   = memWrite  & ~reset;
  assign bus.reg_write   = regWrite  & ~reset;
  assign bus.instr_done  = instrDone & ~reset;
  assign bus.illegal_op  = illegalOp & ~reset;
  assign bus.i_or_d      = iOrD;
  assign bus.reg_dst     = regDst;
  assign bus.mem_to_reg  = memToReg;
  assign bus.alu_src_a   = aluSrcA;
  assign bus.alu_src_b   = aluSrcB;
  assign bus.alu_control = aluControl;
  assign bus.pc_src      = pcSrc;

  assign dbgState = state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl
//   Directed and randomized checks of the multi-cycle control unit against a
//   phase-list model: each instruction class expands to its list of phases,
//   memory phases repeat while mem_ready is low, and every cycle's outputs
//   are derived from the phase name.
module tb_mips_multicycle_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_multicycle_ctrl_if bus ();
  logic [3:0] dbgState;

  mips_multicycle_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .dbgState (dbgState)
  );

  // ---------------- model vocabulary ----------------
  localparam int PH_FETCH  = 0;
  localparam int PH_DEC    = 1;
  localparam int PH_DECILL = 2;
  localparam int PH_ADDR   = 3;
  localparam int PH_READ   = 4;
  localparam int PH_LDWB   = 5;
  localparam int PH_WRITE  = 6;
  localparam int PH_EXEC   = 7;
  localparam int PH_RWB    = 8;
  localparam int PH_BR     = 9;
  localparam int PH_IEX    = 10;
  localparam int PH_IWB    = 11;
  localparam int PH_JMP    = 12;

  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_RBAD = 3, C_BEQ = 4,
                 C_ADDI = 5, C_J = 6, C_ILL = 7;

  int nCmp = 0;
  int nErr = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nCmp++;
    assert (obs === expv) else begin
      nErr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // {pc_en, ir_write, i_or_d, mem_write, reg_write, reg_dst, mem_to_reg,
  //  alu_src_a, alu_src_b[1:0], alu_control[2:0], pc_src[1:0], instr_done, illegal_op}
  function automatic logic [31:0] obsVec();
    return {15'd0, bus.pc_en, bus.ir_write, bus.i_or_d, bus.mem_write,
            bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a,
            bus.alu_src_b, bus.alu_control, bus.pc_src, bus.instr_done,
            bus.illegal_op};
  endfunction

  function automatic logic [2:0] aluOfFunct(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'bxxx;
    endcase
  endfunction

  function automatic logic [31:0] expOut(input int ph, input logic rdy,
                                         input logic z, input logic [5:0] fn);
    logic pe, irw, iod, mw, rw, rd, m2r, sa, dn, il;
    logic [1:0] sb, ps;
    logic [2:0] alu;
    pe = 0; irw = 0; iod = 0; mw = 0; rw = 0; rd = 0; m2r = 0; sa = 0;
    dn = 0; il = 0; sb = 2'b00; ps = 2'b00; alu = 3'b010;
    case (ph)
      PH_FETCH:  begin sb = 2'b01; pe = rdy; irw = rdy; end
      PH_DEC:    begin sb = 2'b10; end
      PH_DECILL: begin sb = 2'b10; il = 1; dn = 1; end
      PH_ADDR:   begin sa = 1; sb = 2'b10; end
      PH_READ:   begin iod = 1; end
      PH_LDWB:   begin rw = 1; m2r = 1; dn = 1; end
      PH_WRITE:  begin iod = 1; mw = 1; dn = rdy; end
      PH_EXEC:   begin sa = 1; alu = aluOfFunct(fn); end
      PH_RWB:    begin rw = 1; rd = 1; dn = 1; end
      PH_BR:     begin sa = 1; alu = 3'b110; ps = 2'b01; pe = z; dn = 1; end
      PH_IEX:    begin sa = 1; sb = 2'b10; end
      PH_IWB:    begin rw = 1; dn = 1; end
      PH_JMP:    begin ps = 2'b10; pe = 1; dn = 1; end
      default:   ;
    endcase
    return {15'd0, pe, irw, iod, mw, rw, rd, m2r, sa, sb, alu, ps, dn, il};
  endfunction

  // Fetch-state selects with every enable low: what reset must present.
  function automatic logic [31:0] resetVec();
    return expOut(PH_FETCH, 1'b0, 1'b0, 6'd0);
  endfunction

  // ---------------- driver ----------------
  // Runs one instruction starting in FETCH. directed=1 takes mem_ready per
  // cycle from rdyMask and zero from zv; otherwise both are random.
  task automatic runInstr(input string name, input int cls, input logic [5:0] fn,
                          input logic [5:0] illOp, input bit directed,
                          input logic [31:0] rdyMask, input logic zv,
                          output int memWrCyc, output int regWrCyc);
    int ph[$];
    int cyc, dutDone, waits;
    logic rdy, z;
    logic [5:0] op;
    memWrCyc = 0; regWrCyc = 0;
    op = 6'd0;
    case (cls)
      C_LW:   begin op = 6'b100011; ph = '{PH_FETCH, PH_DEC, PH_ADDR, PH_READ, PH_LDWB}; end
      C_SW:   begin op = 6'b101011; ph = '{PH_FETCH, PH_DEC, PH_ADDR, PH_WRITE}; end
      C_R:    begin op = 6'b000000; ph = '{PH_FETCH, PH_DEC, PH_EXEC, PH_RWB}; end
      C_RBAD: begin op = 6'b000000; ph = '{PH_FETCH, PH_DECILL}; end
      C_BEQ:  begin op = 6'b000100; ph = '{PH_FETCH, PH_DEC, PH_BR}; end
      C_ADDI: begin op = 6'b001000; ph = '{PH_FETCH, PH_DEC, PH_IEX, PH_IWB}; end
`ifdef MC_CTRL_JUMP_EN
      C_J:    begin op = 6'b000010; ph = '{PH_FETCH, PH_DEC, PH_JMP}; end
`else
      C_J:    begin op = 6'b000010; ph = '{PH_FETCH, PH_DECILL}; end
`endif
      default: begin op = illOp; ph = '{PH_FETCH, PH_DECILL}; end
    endcase
    cyc = 0; dutDone = -1; waits = 0;
    while (ph.size() > 0 && cyc < 64) begin
      @(negedge clk);
      if (directed) begin
        rdy = rdyMask[cyc[4:0]];
        z   = zv;
      end else begin
        rdy = (waits >= 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
        z   = 1'($urandom_range(0, 1));
      end
      bus.opcode    = op;
      bus.funct     = fn;
      bus.mem_ready = rdy;
      bus.zero      = z;
      #1;
      exp_q.push_back(expOut(ph[0], rdy, z, fn));
      check($sformatf("%s cyc%0d", name, cyc), obsVec(), exp_q.pop_front());
      if (bus.instr_done === 1'b1 && dutDone < 0) dutDone = cyc + 1;
      if (bus.mem_write === 1'b1) memWrCyc++;
      if (bus.reg_write === 1'b1) regWrCyc++;
      if ((ph[0] == PH_FETCH || ph[0] == PH_READ || ph[0] == PH_WRITE) && !rdy) begin
        waits++;
      end else begin
        void'(ph.pop_front());
        waits = 0;
      end
      cyc++;
    end
    check({name, " cycles"}, 32'(dutDone), 32'(cyc));
  endtask

  // ---------------- stimulus ----------------
  int mw, rw, cls;
  logic [5:0] fn, ill;
  logic [5:0] goodFn[5];

  initial begin
    goodFn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    bus.opcode = 6'd0; bus.funct = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    reset = 1'b1;
    #1;
    check("reset outputs", obsVec(), resetVec());
    @(negedge clk);
    check("reset held outputs", obsVec(), resetVec());
    reset = 1'b0;
    #1;
    check("first fetch enables", obsVec(), expOut(PH_FETCH, 1'b1, 1'b0, 6'd0));
    bus.mem_ready = 1'b0;  // hold FETCH until the first runInstr cycle

    runInstr("lw", C_LW, 6'd0, 6'd0, 1'b1, 32'hFFFF_FFFF, 1'b0, mw, rw);
    check("lw reg_write cycles", 32'(rw), 32'd1);
    runInstr("sub", C_R, 6'b100010, 6'd0, 1'b1, 32'hFFFF_FFFF, 1'b0, mw, rw);
    runInstr("beq taken", C_BEQ, 6'd0, 6'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, mw, rw);
    runInstr("beq not taken", C_BEQ, 6'd0, 6'd0, 1'b1, 32'hFFFF_FFFF, 1'b0, mw, rw);
    // Two wait cycles inside MEMWRITE (cycles 3 and 4).
    runInstr("sw wait2", C_SW, 6'd0, 6'd0, 1'b1, ~32'h18, 1'b0, mw, rw);
    check("sw mem_write cycles", 32'(mw), 32'd3);
    check("sw reg_write cycles", 32'(rw), 32'd0);
    runInstr("op000010", C_J, 6'd0, 6'd0, 1'b1, 32'hFFFF_FFFF, 1'b0, mw, rw);
    runInstr("rtype bad funct", C_RBAD, 6'b000111, 6'd0, 1'b1, 32'hFFFF_FFFF, 1'b0, mw, rw);
    runInstr("addi", C_ADDI, 6'd0, 6'd0, 1'b1, 32'hFFFF_FFFF, 1'b0, mw, rw);

    // Reset asserted while lw waits in MEMREAD.
    bus.opcode = 6'b100011; bus.funct = 6'd0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.mem_ready = (c < 3);
    end
    #1;
    check("lw in memread", obsVec(), expOut(PH_READ, 1'b0, 1'b0, 6'd0));
    reset = 1'b1;
    #1;
    check("reset mid memread", obsVec(), resetVec());
    @(negedge clk);
    bus.mem_ready = 1'b1;
    #1;
    check("reset next cycle", obsVec(), resetVec());
    reset = 1'b0;
    #1;
    check("fetch after abort", obsVec(), expOut(PH_FETCH, 1'b1, 1'b0, 6'd0));
    bus.mem_ready = 1'b0;

    // Randomized instruction mix with random wait states and zero flag.
    for (int n = 0; n < 80; n++) begin
      cls = $urandom_range(0, 7);
      fn  = goodFn[$urandom_range(0, 4)];
      if (cls == C_RBAD) begin
        do fn = 6'($urandom_range(0, 63));
        while (fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
               fn == 6'b100101 || fn == 6'b101010);
      end
      do ill = 6'($urandom_range(0, 63));
      while (ill == 6'b000000 || ill == 6'b000010 || ill == 6'b000100 ||
             ill == 6'b001000 || ill == 6'b100011 || ill == 6'b101011);
      runInstr($sformatf("rand%0d cls%0d", n, cls), cls, fn, ill, 1'b0, 32'd0, 1'b0, mw, rw);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
